reg_show_display: RTL and testbench

- Downstream consumer of the Microcontroller's register-show outputs (show strobes and 8-bit register values).
- Captures each show event into a small tagged FIFO and presents one entry at a time on a 4-digit multiplexed 7-segment display.
- Each entry is held for a fixed time so that fast instruction streams remain readable.
- Sits between the Microcontroller top and the board display pins, clocked by the CPU clock.

---
 rtl/reg_show_display_if.sv | 23 ++
 rtl/reg_show_display.sv | 110 +++++++++++
 tb/tb_reg_show_display.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_show_display_if.sv
// reg_show_display_if: register-show strobes/values in, display pins and FIFO status out
interface reg_show_display_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          i_ShowR1;
  logic                          i_ShowR2;
  logic [7:0]                    i_RegShowing1;
  logic [7:0]                    i_RegShowing2;
  logic [6:0]                    o_SEG;
  logic [3:0]                    o_AN;
  logic                          o_Empty;
  logic                          o_Full;
  logic [$clog2(FIFO_DEPTH):0]   o_Count;
  logic [7:0]                    o_DropCnt;
  modport master (
    output i_ShowR1, i_ShowR2, i_RegShowing1, i_RegShowing2,
    input  o_SEG, o_AN, o_Empty, o_Full, o_Count, o_DropCnt
  );
  modport slave (
    input  i_ShowR1, i_ShowR2, i_RegShowing1, i_RegShowing2,
    output o_SEG, o_AN, o_Empty, o_Full, o_Count, o_DropCnt
  );
endinterface

// File: rtl/reg_show_display.sv
// reg_show_display: queues register-show events and shows each on a 4-digit 7-segment display
module reg_show_display #(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_CYCLES = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  reg_show_display_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {IDLE, SHOW} state_t;
  state_t        state_q, state_d;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d, free;
  logic          empty_q, empty_d, full_q, full_d;
  logic [7:0]    drop_q, drop_d;
  logic [8:0]    drop_sum;
  logic [8:0]    disp_q, disp_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic          prev1_q, prev2_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          e1, e2, push1, push2, pop, hold_end, scan_end;
  // edge detect, overflow arbitration, FIFO bookkeeping, display FSM and scan next-state
  always_comb begin
    e1       = bus.i_ShowR1 & ~prev1_q;
    e2       = bus.i_ShowR2 & ~prev2_q;
    hold_end = hold_q == HW'(HOLD_CYCLES - 1);
    pop      = (count_q != '0) && (state_q == IDLE || hold_end);
    free     = CW'(FIFO_DEPTH) - count_q + CW'(pop);
    push1    = e1 && free != '0;
    push2    = e2 && free > (push1 ? CW'(1) : CW'(0));
    count_d  = count_q + CW'(push1) + CW'(push2) - CW'(pop);
    empty_d  = count_d == '0;
    full_d   = count_d == CW'(FIFO_DEPTH);
    wr_d     = wr_q + AW'(push1) + AW'(push2);
    rd_d     = rd_q + AW'(pop);
    drop_sum = {1'b0, drop_q} + 9'(e1 & ~push1) + 9'(e2 & ~push2);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    disp_d   = pop ? mem[rd_q] : disp_q;
    state_d  = pop ? SHOW : state_q;
    hold_d   = pop ? '0 : (state_q == SHOW && !hold_end) ? hold_q + 1'b1 : hold_q;
    scan_end = scan_q == SW'(SCAN_DIV - 1);
    scan_d   = state_q == SHOW ? (scan_end ? '0 : scan_q + 1'b1) : scan_q;
    idx_d    = idx_q + 2'(state_q == SHOW && scan_end);
    an_d     = state_d == SHOW ? ~(4'b1 << idx_d) : 4'hF;
    seg_d    = state_d != SHOW ? 7'h7F :
               idx_d == 2'd3 ? (disp_d[8] ? 7'h24 : 7'h79) :
               idx_d == 2'd2 ? 7'h7F :
               HEX[idx_d[0] ? disp_d[7:4] : disp_d[3:0]];
  end
  // FIFO storage; R2 lands in the slot after R1 when both are kept
  always_ff @(posedge i_CLK) begin
    if (push1) mem[wr_q] <= {1'b0, bus.i_RegShowing1};
    if (push2) mem[wr_q + AW'(push1)] <= {1'b1, bus.i_RegShowing2};
  end
  // state registers; reset wins over any same-cycle push, pop or scan
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      drop_q  <= '0;
      disp_q  <= '0;
      hold_q  <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      prev1_q <= 1'b0;
      prev2_q <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
      disp_q  <= disp_d;
      hold_q  <= hold_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      prev1_q <= bus.i_ShowR1;
      prev2_q <= bus.i_ShowR2;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end
  assign bus.o_SEG     = seg_q;
  assign bus.o_AN      = an_q;
  assign bus.o_Empty   = empty_q;
  assign bus.o_Full    = full_q;
  assign bus.o_Count   = count_q;
  assign bus.o_DropCnt = drop_q;
endmodule

// File: tb/tb_reg_show_display.sv
// tb_reg_show_display: directed scenario tests for reg_show_display (SCAN_DIV=4, HOLD_CYCLES=16, FIFO_DEPTH=4)
module tb_reg_show_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [6:0] hex [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  reg_show_display_if #(.FIFO_DEPTH(4)) bus ();
  reg_show_display #(.SCAN_DIV(4), .HOLD_CYCLES(16), .FIFO_DEPTH(4)) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.i_ShowR1 = 1'b0;
    bus.i_ShowR2 = 1'b0;
    bus.i_RegShowing1 = 8'h00;
    bus.i_RegShowing2 = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.o_AN !== 4'hF || bus.o_SEG !== 7'h7F || bus.o_Empty !== 1'b1 ||
          bus.o_Full !== 1'b0 || bus.o_Count !== 3'd0 || bus.o_DropCnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: an=%h seg=%h empty=%b full=%b count=%0d drop=%0d want an=f seg=7f empty=1 full=0 count=0 drop=0",
                 i, bus.o_AN, bus.o_SEG, bus.o_Empty, bus.o_Full, bus.o_Count, bus.o_DropCnt);
      end
    end
  endtask
  task automatic test_single_r1();
    logic [3:0] ex_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] ex_seg [4] = '{7'h08, 7'h30, 7'h7F, 7'h79};
    bus.i_ShowR1 = 1'b1;
    bus.i_RegShowing1 = 8'h3A;
    tick();
    checks++;
    if (bus.o_Empty !== 1'b0 || bus.o_Count !== 3'd1) begin
      errors++;
      $display("FAIL single_push: empty=%b count=%0d want empty=0 count=1", bus.o_Empty, bus.o_Count);
    end
    bus.i_ShowR1 = 1'b0;
    tick();
    checks++;
    if (bus.o_Empty !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: empty=%b want 1", bus.o_Empty);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.o_AN !== ex_an[k/4] || bus.o_SEG !== ex_seg[k/4]) begin
        errors++;
        $display("FAIL single_scan k=%0d: an=%h seg=%h want an=%h seg=%h", k, bus.o_AN, bus.o_SEG, ex_an[k/4], ex_seg[k/4]);
      end
      tick();
    end
  endtask
  task automatic test_held_r2();
    logic [6:0] ex [4] = '{7'h12, 7'h46, 7'h7F, 7'h24};
    int d;
    bus.i_ShowR2 = 1'b1;
    bus.i_RegShowing2 = 8'hC5;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.o_Count !== (i == 0 ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL held_count cyc=%0d: count=%0d want %0d", i, bus.o_Count, (i == 0 ? 1 : 0));
      end
    end
    bus.i_ShowR2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      d = bus.o_AN == 4'hE ? 0 : bus.o_AN == 4'hD ? 1 : bus.o_AN == 4'hB ? 2 : bus.o_AN == 4'h7 ? 3 : -1;
      checks++;
      if (d < 0 || bus.o_SEG !== ex[d]) begin
        errors++;
        $display("FAIL held_digits k=%0d: an=%h seg=%h want display 2 C5", k, bus.o_AN, bus.o_SEG);
      end
      tick();
    end
  endtask
  task automatic test_both_edges();
    logic [6:0] ex_a [4] = '{7'h79, 7'h79, 7'h7F, 7'h79};
    logic [6:0] ex_b [4] = '{7'h24, 7'h24, 7'h7F, 7'h24};
    logic [6:0] want;
    int d;
    bus.i_ShowR1 = 1'b1;
    bus.i_ShowR2 = 1'b1;
    bus.i_RegShowing1 = 8'h11;
    bus.i_RegShowing2 = 8'h22;
    tick();
    checks++;
    if (bus.o_Count !== 3'd2) begin
      errors++;
      $display("FAIL both_push: count=%0d want 2", bus.o_Count);
    end
    bus.i_ShowR1 = 1'b0;
    bus.i_ShowR2 = 1'b0;
    tick();
    checks++;
    if (bus.o_Count !== 3'd1) begin
      errors++;
      $display("FAIL both_first_pop: count=%0d want 1", bus.o_Count);
    end
    for (int k = 0; k < 48; k++) begin
      d = bus.o_AN == 4'hE ? 0 : bus.o_AN == 4'hD ? 1 : bus.o_AN == 4'hB ? 2 : bus.o_AN == 4'h7 ? 3 : -1;
      want = d < 0 ? 7'h7F : (k < 16 ? ex_a[d] : ex_b[d]);
      checks++;
      if (d < 0 || bus.o_SEG !== want) begin
        errors++;
        $display("FAIL both_digits k=%0d: an=%h seg=%h want %s", k, bus.o_AN, bus.o_SEG, k < 16 ? "1 11" : "2 22");
      end
      if (k == 16) begin
        checks++;
        if (bus.o_Count !== 3'd0) begin
          errors++;
          $display("FAIL both_second_pop: count=%0d want 0", bus.o_Count);
        end
      end
      tick();
    end
  endtask
  task automatic test_overflow();
    logic [6:0] ex [4];
    int d;
    bus.i_ShowR1 = 1'b1;
    bus.i_RegShowing1 = 8'h01;
    tick();
    bus.i_ShowR1 = 1'b0;
    tick();
    for (int j = 0; j < 6; j++) begin
      bus.i_ShowR1 = 1'b1;
      bus.i_RegShowing1 = 8'(8'h02 + j);
      tick();
      bus.i_ShowR1 = 1'b0;
      tick();
    end
    checks++;
    if (bus.o_Full !== 1'b1 || bus.o_Count !== 3'd4 || bus.o_DropCnt !== 8'd2) begin
      errors++;
      $display("FAIL overflow_state: full=%b count=%0d drop=%0d want full=1 count=4 drop=2", bus.o_Full, bus.o_Count, bus.o_DropCnt);
    end
    for (int i = 0; i < 4; i++) tick();
    for (int e = 0; e < 4; e++) begin
      ex = '{hex[2 + e], 7'h40, 7'h7F, 7'h79};
      checks++;
      if (bus.o_Count !== 3'(3 - e) || bus.o_Full !== 1'b0) begin
        errors++;
        $display("FAIL overflow_drain e=%0d: count=%0d full=%b want count=%0d full=0", e, bus.o_Count, bus.o_Full, 3 - e);
      end
      for (int k = 0; k < 16; k++) begin
        d = bus.o_AN == 4'hE ? 0 : bus.o_AN == 4'hD ? 1 : bus.o_AN == 4'hB ? 2 : bus.o_AN == 4'h7 ? 3 : -1;
        checks++;
        if (d < 0 || bus.o_SEG !== ex[d]) begin
          errors++;
          $display("FAIL overflow_order e=%0d k=%0d: an=%h seg=%h want display 1 0%0d", e, k, bus.o_AN, bus.o_SEG, 2 + e);
        end
        tick();
      end
    end
  endtask
  task automatic test_reset_mid();
    bus.i_ShowR1 = 1'b1;
    bus.i_RegShowing1 = 8'hA1;
    tick();
    bus.i_ShowR1 = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      bus.i_ShowR1 = 1'b1;
      bus.i_RegShowing1 = 8'(8'hB0 + j);
      tick();
      bus.i_ShowR1 = 1'b0;
      tick();
    end
    checks++;
    if (bus.o_Count !== 3'd3 || bus.o_AN === 4'hF) begin
      errors++;
      $display("FAIL mid_before_reset: count=%0d an=%h want count=3 with a digit lit", bus.o_Count, bus.o_AN);
    end
    rst = 1'b1;
    bus.i_ShowR1 = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_ShowR1 = 1'b0;
    checks++;
    if (bus.o_Count !== 3'd0 || bus.o_Empty !== 1'b1 || bus.o_Full !== 1'b0 ||
        bus.o_AN !== 4'hF || bus.o_SEG !== 7'h7F || bus.o_DropCnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b full=%b an=%h seg=%h drop=%0d want 0 1 0 f 7f 0",
               bus.o_Count, bus.o_Empty, bus.o_Full, bus.o_AN, bus.o_SEG, bus.o_DropCnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_AN !== 4'hF || bus.o_Empty !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_idle cyc=%0d: an=%h empty=%b want an=f empty=1", i, bus.o_AN, bus.o_Empty);
      end
    end
  endtask
  task automatic test_drop_saturate();
    for (int i = 0; i < 400; i++) begin
      bus.i_ShowR1 = (i % 2) == 0;
      bus.i_ShowR2 = (i % 2) == 0;
      bus.i_RegShowing1 = 8'(i);
      bus.i_RegShowing2 = 8'(~i);
      tick();
    end
    checks++;
    if (bus.o_DropCnt !== 8'hFF) begin
      errors++;
      $display("FAIL drop_saturate: drop=%0d want 255", bus.o_DropCnt);
    end
    for (int i = 0; i < 8; i++) begin
      bus.i_ShowR1 = (i % 2) == 0;
      bus.i_ShowR2 = (i % 2) == 0;
      tick();
    end
    bus.i_ShowR1 = 1'b0;
    bus.i_ShowR2 = 1'b0;
    checks++;
    if (bus.o_DropCnt !== 8'hFF) begin
      errors++;
      $display("FAIL drop_hold: drop=%0d want 255", bus.o_DropCnt);
    end
  endtask
  initial begin
    test_reset();
    test_single_r1();
    test_held_r2();
    test_both_edges();
    test_overflow();
    test_reset_mid();
    test_drop_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
